// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared state type and preamble defaults for the serial frame link
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        PAR,
        GAP
    } tx_state_t;

    localparam logic [3:0] DEF_PREAMBLE     = 4'b1101;
    localparam int         DEF_PREAMBLE_LEN = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// rtl/serial_bit_timer.sv - clocks-per-bit counter; bit_tick marks the last clock of each bit
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_tick,
    output logic next_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!en || count == CNT_LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_tick = en && (count == CNT_LAST);

    // next_tick: the following clock will be the last clock of a bit (lets callers register pulses)
    generate
        if (CLKS_PER_BIT == 1) begin : g_single
            assign next_tick = 1'b1;
        end else begin : g_multi
            localparam logic [CNT_W-1:0] CNT_PEN = CNT_W'(CLKS_PER_BIT - 2);
            assign next_tick = en && (count == CNT_PEN);
        end
    endgenerate

endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - serialises a word as preamble + payload + idle gap
// Optional even-parity bit after the payload: define SERIAL_FRAME_TX_PARITY_EN.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int                      DATA_WIDTH   = 8,
    parameter int                      PREAMBLE_LEN = DEF_PREAMBLE_LEN,
    parameter logic [PREAMBLE_LEN-1:0] PREAMBLE     = DEF_PREAMBLE,
    parameter int                      GAP_BITS     = 2,
    parameter int                      CLKS_PER_BIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int IDX_MAX = max3(PREAMBLE_LEN, DATA_WIDTH, GAP_BITS);
    localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

    localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PREAMBLE_LEN - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] GAP_LAST  = IDX_W'(GAP_BITS - 1);
    localparam logic [IDX_W-1:0] GAP_PEN   = IDX_W'((GAP_BITS > 1) ? GAP_BITS - 2 : 0);

    tx_state_t             state;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  bit_tick;
    logic                  next_tick;
    logic                  pre_next_bit;
    logic                  last_payload_bit;
    logic                  enters_last_gap;
    logic                  last_gap_next;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic                  parity_bit;
`endif

    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (busy),
        .bit_tick (bit_tick),
        .next_tick(next_tick)
    );

    always_comb begin
        pre_next_bit = 1'b0;
        for (int i = 0; i < PREAMBLE_LEN; i++) begin
            if (i == PREAMBLE_LEN - 2 - int'(idx)) begin
                pre_next_bit = PREAMBLE[i];
            end
        end
    end

`ifdef SERIAL_FRAME_TX_PARITY_EN
    assign last_payload_bit = (state == PAR);
`else
    assign last_payload_bit = (state == DATA) && (idx == DATA_LAST);
`endif

    // frame_done is registered, so predict when the next clock is the final clock of the last gap bit
    always_comb begin
        enters_last_gap = (GAP_BITS == 1) ? last_payload_bit : ((state == GAP) && (idx == GAP_PEN));
        last_gap_next   = next_tick &&
                          ((bit_tick && enters_last_gap) ||
                           (!bit_tick && (state == GAP) && (idx == GAP_LAST)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            shreg      <= '0;
            serial_out <= 1'b0;
            tx_ready   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            frame_done <= last_gap_next;
            case (state)
                IDLE: begin
                    idx        <= '0;
                    serial_out <= 1'b0;
                    if (tx_valid && tx_ready) begin
                        shreg      <= tx_data;
                        state      <= PRE;
                        serial_out <= PREAMBLE[PREAMBLE_LEN-1];
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        parity_bit <= ^tx_data;
`endif
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                PRE: begin
                    if (bit_tick) begin
                        if (idx == PRE_LAST) begin
                            state      <= DATA;
                            idx        <= '0;
                            serial_out <= shreg[DATA_WIDTH-1];
                            shreg      <= shreg << 1;
                        end else begin
                            idx        <= idx + 1'b1;
                            serial_out <= pre_next_bit;
                        end
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (idx == DATA_LAST) begin
                            idx <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                            state      <= PAR;
                            serial_out <= parity_bit;
`else
                            state      <= GAP;
                            serial_out <= 1'b0;
`endif
                        end else begin
                            idx        <= idx + 1'b1;
                            serial_out <= shreg[DATA_WIDTH-1];
                            shreg      <= shreg << 1;
                        end
                    end
                end
`ifdef SERIAL_FRAME_TX_PARITY_EN
                PAR: begin
                    if (bit_tick) begin
                        state      <= GAP;
                        idx        <= '0;
                        serial_out <= 1'b0;
                    end
                end
`endif
                GAP: begin
                    serial_out <= 1'b0;
                    if (bit_tick) begin
                        if (idx == GAP_LAST) begin
                            state    <= IDLE;
                            idx      <= '0;
                            shreg    <= '0;
                            busy     <= 1'b0;
                            tx_ready <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    idx        <= '0;
                    serial_out <= 1'b0;
                    busy       <= 1'b0;
                    tx_ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - self-checking bench for serial_frame_tx (CLKS_PER_BIT 1 and 4)
module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int BITS = 4 + 8 + PBITS + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d1 = 8'h00, d4 = 8'h00;
    logic       v1 = 1'b0, v4 = 1'b0;
    logic       r1, s1, b1, f1;
    logic       r4, s4, b4, f4;

    int checks = 0;
    int passed = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    serial_frame_tx #(.CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1),
        .tx_ready(r1), .serial_out(s1), .busy(b1), .frame_done(f1)
    );

    serial_frame_tx #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .tx_data(d4), .tx_valid(v4),
        .tx_ready(r4), .serial_out(s4), .busy(b4), .frame_done(f4)
    );

    typedef struct {
        logic [7:0] word;
        int         sel;
        int         exp_clocks;
        bit         exp_par;
    } vec_t;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic logic rdy(input int sel);
        return sel != 0 ? r4 : r1;
    endfunction

    task automatic drive(input int sel, input logic [7:0] w, input logic v);
        if (sel != 0) begin d4 = w; v4 = v; end
        else begin d1 = w; v1 = v; end
    endtask

    // reference frame: preamble, payload MSB first, optional even parity, zero gap; each bit held cpb clocks
    task automatic build_frame(input logic [7:0] w, input int cpb);
        bit         bits[$];
        logic [3:0] pre;
        pre = 4'b1101;
        bits = {};
        for (int i = 3; i >= 0; i--) bits.push_back(pre[i]);
        for (int i = 7; i >= 0; i--) bits.push_back(w[i]);
        if (PBITS == 1) bits.push_back(^w);
        for (int i = 0; i < 2; i++) bits.push_back(1'b0);
        exp_q = {};
        foreach (bits[i]) for (int c = 0; c < cpb; c++) exp_q.push_back(bits[i]);
    endtask

    task automatic run_frame(input int sel, input logic [7:0] w, input string name,
                             output logic [63:0] cap, output int fd_first);
        int len, waited, bit_errs, busy_errs, fd_cnt;
        logic so, fd, bz;
        build_frame(w, sel != 0 ? 4 : 1);
        len = exp_q.size();
        cap = '0; fd_first = -1; bit_errs = 0; busy_errs = 0; fd_cnt = 0; waited = 0;
        @(negedge clk);
        drive(sel, w, 1'b1);
        while (!rdy(sel) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) check(1'b0, {name, "_ready_timeout"}, waited, 200);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (k == 0) drive(sel, 8'($urandom), 1'b0);
            so = sel != 0 ? s4 : s1;
            fd = sel != 0 ? f4 : f1;
            bz = sel != 0 ? b4 : b1;
            cap = {cap[62:0], so};
            if (so !== exp_q[k]) bit_errs++;
            if (bz !== 1'b1) busy_errs++;
            if (fd === 1'b1) begin
                fd_cnt++;
                if (fd_first < 0) fd_first = k;
            end
        end
        check(bit_errs == 0, {name, "_serial_bits"}, bit_errs, 0);
        check(busy_errs == 0, {name, "_busy_during_frame"}, busy_errs, 0);
        check(fd_cnt == 1 && fd_first == len - 1, {name, "_frame_done_cycle"}, fd_first + 1, len);
        @(negedge clk);
        check(rdy(sel) === 1'b1 && (sel != 0 ? b4 : b1) === 1'b0, {name, "_idle_after"},
              rdy(sel), 1);
    endtask

    vec_t        tbl[5];
    logic [63:0] cap;
    int          fdf;

    initial begin
        tbl[0] = '{word: 8'hA5, sel: 0, exp_clocks: BITS,     exp_par: 1'b0};
        tbl[1] = '{word: 8'h81, sel: 1, exp_clocks: BITS * 4, exp_par: 1'b0};
        tbl[2] = '{word: 8'h07, sel: 0, exp_clocks: BITS,     exp_par: 1'b1};
        tbl[3] = '{word: 8'h03, sel: 0, exp_clocks: BITS,     exp_par: 1'b0};
        tbl[4] = '{word: 8'hE6, sel: 1, exp_clocks: BITS * 4, exp_par: 1'b1};

        // reset held with tx_valid high: everything quiet
        v1 = 1'b1; v4 = 1'b1; d1 = 8'hFF; d4 = 8'hFF;
        repeat (3) @(negedge clk);
        check(s1 === 1'b0 && r1 === 1'b0 && b1 === 1'b0 && f1 === 1'b0, "reset_outputs_dut1",
              {s1, r1, b1, f1}, 0);
        check(s4 === 1'b0 && r4 === 1'b0 && b4 === 1'b0 && f4 === 1'b0, "reset_outputs_dut4",
              {s4, r4, b4, f4}, 0);
        rst = 1'b0; v1 = 1'b0; v4 = 1'b0;
        @(negedge clk);
        check(r1 === 1'b1 && r4 === 1'b1, "ready_after_reset", {r1, r4}, 3);

        foreach (tbl[i]) begin
            run_frame(tbl[i].sel, tbl[i].word, $sformatf("vec%0d", i), cap, fdf);
            check(fdf + 1 == tbl[i].exp_clocks, $sformatf("vec%0d_frame_clocks", i),
                  fdf + 1, tbl[i].exp_clocks);
            if (tbl[i].sel == 0 && PBITS == 1)
                check(cap[2] === tbl[i].exp_par, $sformatf("vec%0d_parity", i), cap[2], tbl[i].exp_par);
            if (i == 0) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                check(cap[14:0] === 15'b110110100101000, "a5_literal_stream", cap[14:0], 15'b110110100101000);
`else
                check(cap[13:0] === 14'b11011010010100, "a5_literal_stream", cap[13:0], 14'b11011010010100);
`endif
            end
        end

        // back-to-back: FF then 00 with tx_valid held high
        begin
            bit two_q[$];
            int waited, errs, rdy_cnt, rdy_pos, fd_cnt;
            build_frame(8'hFF, 1); two_q = exp_q; two_q.push_back(1'b0);
            build_frame(8'h00, 1); two_q = {two_q, exp_q};
            waited = 0; errs = 0; rdy_cnt = 0; rdy_pos = -1; fd_cnt = 0;
            @(negedge clk);
            drive(0, 8'hFF, 1'b1);
            while (!r1 && waited < 200) begin @(negedge clk); waited++; end
            if (waited >= 200) check(1'b0, "b2b_ready_timeout", waited, 200);
            for (int k = 0; k < two_q.size(); k++) begin
                @(negedge clk);
                if (k == 0) d1 = 8'h00;
                if (k == BITS + 1) v1 = 1'b0;
                if (s1 !== two_q[k]) errs++;
                if (r1 === 1'b1) begin rdy_cnt++; rdy_pos = k; end
                if (f1 === 1'b1) fd_cnt++;
            end
            check(errs == 0, "b2b_stream", errs, 0);
            check(rdy_cnt == 1 && rdy_pos == BITS, "b2b_ready_single_cycle", rdy_pos, BITS);
            check(fd_cnt == 2, "b2b_frame_done_count", fd_cnt, 2);
        end

        // async reset during payload bit 3 of 8'h96 (bit value 1)
        begin
            int waited, fd_cnt;
            waited = 0; fd_cnt = 0;
            @(negedge clk);
            drive(0, 8'h96, 1'b1);
            while (!r1 && waited < 200) begin @(negedge clk); waited++; end
            if (waited >= 200) check(1'b0, "abort_ready_timeout", waited, 200);
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (k == 0) v1 = 1'b0;
            end
            check(s1 === 1'b1 && b1 === 1'b1, "abort_before_reset", s1, 1);
            #1 rst = 1'b1;
            #1 check(s1 === 1'b0 && b1 === 1'b0 && r1 === 1'b0, "abort_async_clear", {s1, b1, r1}, 0);
            @(negedge clk);
            rst = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (f1 === 1'b1 || b1 === 1'b1) fd_cnt++;
            end
            check(fd_cnt == 0, "abort_no_frame_done", fd_cnt, 0);
        end
        run_frame(0, 8'h3C, "after_abort", cap, fdf);

        // randomized words on either instance
        for (int n = 0; n < 16; n++) begin
            int sel;
            sel = int'($urandom_range(0, 1));
            run_frame(sel, 8'($urandom), $sformatf("rand%0d", n), cap, fdf);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Transmit-side partner of the Moore serial sequence detector in the packet processor.
- Accepts a parallel word over a valid/ready handshake and serialises it as a frame: preamble 1101, then payload MSB first, then idle gap bits.
- The downstream detector on the serial line sees the 1101 preamble and locks onto the frame.
- Sits between the packet-builder logic and the serial link pin.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- PREAMBLE, 4'b1101, preamble pattern, sent MSB first.
- PREAMBLE_LEN, 4, width of PREAMBLE.
- GAP_BITS, 2, minimum idle-0 bits after each frame; must be ≥1.
- CLKS_PER_BIT, 1, clock cycles each serial bit is held; must be ≥1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_data  input  DATA_WIDTH  payload word; sampled on handshake.
- tx_valid  input  1  upstream has a word.
- tx_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  registered serial line; idle level 0.
- busy  output  1  frame in progress, including gap.
- frame_done  output  1  one-cycle pulse when the last gap bit completes.

Behaviour:
- Reset (async, active-high), while rst=1:
  - serial_out=0, tx_ready=0, busy=0, frame_done=0.
  - State=IDLE; all counters and the shift register are 0.
  - tx_ready rises in the first cycle after rst deasserts.
- Reset mid-frame aborts the frame immediately. No frame_done pulse. The word is lost.
- FSM states: IDLE, PRE, DATA, (PAR), GAP.
- IDLE:
  - tx_ready=1, serial_out=0, busy=0.
  - Handshake = tx_valid & tx_ready at a rising edge. On it, latch tx_data into the shift register and go to PRE.
  - tx_ready is registered. It drops in the cycle after the handshake and stays low until the return to IDLE.
- Latency: serial_out shows PREAMBLE[PREAMBLE_LEN-1] starting in the clock cycle immediately after the handshake edge.
- Bit timing:
  - A bit counter holds each bit for CLKS_PER_BIT cycles.
  - An index counter advances when the bit counter wraps from CLKS_PER_BIT-1 to 0.
- PRE: send PREAMBLE bits MSB to LSB, PREAMBLE_LEN bits. Then go to DATA, or PAR when the parity feature is enabled after data.
- DATA: send the shift register MSB first, left-shifting once per bit, DATA_WIDTH bits.
- GAP:
  - serial_out=0 for GAP_BITS bit times.
  - frame_done=1 in the final clock of the last gap bit.
  - Next state is IDLE.
- Frame length: (PREAMBLE_LEN + DATA_WIDTH + GAP_BITS) × CLKS_PER_BIT clocks, plus one bit time when parity is enabled.
- busy = (state != IDLE).
- tx_valid high during busy is ignored. tx_data may change freely after the handshake.
- Back-to-back frames: with tx_valid held high, the next handshake happens in the first IDLE cycle. Gap between preambles = GAP_BITS bit times + 1 clock.
- Payload may itself contain 1101. The gap only guarantees the detector sees 0s between frames; the block does no payload scrambling.
- Counter widths are $clog2 of the maximum count. No counter wraps outside its state.

Optional Feature:
- Macro: SERIAL_FRAME_TX_PARITY_EN.
- Defined:
  - State PAR is inserted between DATA and GAP.
  - It sends one even-parity bit, ^tx_data of the latched word, for one bit time.
  - Frame grows by CLKS_PER_BIT clocks.
- Undefined: no PAR state, no parity logic; DATA goes directly to GAP.

Decomposition:
- Package serial_frame_pkg holds:
  - enum tx_state_t {IDLE, PRE, DATA, PAR, GAP};
  - default constants DEF_PREAMBLE=4'b1101 and DEF_PREAMBLE_LEN=4, shared with the detector side.
- One sub-module, serial_bit_timer:
  - CLKS_PER_BIT counter with an enable input and a bit_tick output.
  - Reused by the receive-side oversampler.
- All remaining logic (FSM, shift register, index counter) stays in serial_frame_tx.

Test Plan:
1. Reset: assert rst mid-cycle with tx_valid=1 → serial_out=0, tx_ready=0, busy=0 immediately. After deassert, tx_ready=1 on the next cycle.
2. Single frame, DATA_WIDTH=8, CLKS_PER_BIT=1, tx_data=8'hA5 → serial_out from the cycle after the handshake is 1,1,0,1, 1,0,1,0,0,1,0,1, 0,0. frame_done pulses on cycle 14. Pair with the moore detector: its o asserts after the 4th bit.
3. Back-to-back: tx_valid held high with 8'hFF then 8'h00 → second preamble starts 15 clocks after the first. tx_ready is high for exactly one cycle between frames.
4. Reset mid-frame: assert rst during DATA bit 3 → serial_out=0 at once, no frame_done. A fresh 8'h3C frame after release is bit-exact.
5. CLKS_PER_BIT=4, tx_data=8'h81 → each bit held 4 clocks. Total 56 clocks handshake-to-frame_done.
6. With SERIAL_FRAME_TX_PARITY_EN, tx_data=8'h07 → parity bit 1 after the LSB. With 8'h03 → parity bit 0. Frame length is 15 bit times.
